// File: rtl/dense_layer_pkg.sv
// dense_layer shared definitions: Q-format constants and FSM states.
// Imported by the fully-connected stage and its saturation helper.
package dense_layer_pkg;

  localparam int integer_width  = 10;
  localparam int fraction_width = 10;
  localparam int W              = integer_width + fraction_width;
  localparam int Q_ONE          = 1 << fraction_width;

  localparam logic signed [W-1:0] SAT_MAX = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0] SAT_MIN = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_MAC,
    S_FINISH,
    S_DONE
  } state_t;

endpackage

// File: rtl/dense_layer_if.sv
// dense_layer bus: pooled-map read port, weight load port,
// result read port and completion flag.
interface dense_layer_if;
  import dense_layer_pkg::*;

  logic         in_done;
  logic [8:0]   in_address;
  logic         in_enable;
  logic [W-1:0] in_data;
  logic         weight_we;
  logic [9:0]   weight_addr;
  logic [W-1:0] weight_data;
  logic [8:0]   dense_output_address;
  logic [W-1:0] dense_output_data;
  logic         done;

  modport slave (
    input  in_done, in_data,
    input  weight_we, weight_addr, weight_data,
    input  dense_output_address,
    output in_address, in_enable,
    output dense_output_data, done
  );

  modport master (
    output in_done, in_data,
    output weight_we, weight_addr, weight_data,
    output dense_output_address,
    input  in_address, in_enable,
    input  dense_output_data, done
  );

endinterface

// File: rtl/dense_layer_fxp_saturate.sv
// fxp_saturate: rescale a wide Q(2I).(2F) sum to Q(I).(F),
// optional ReLU, clamp to the signed W-bit range.
module fxp_saturate
  import dense_layer_pkg::*;
#(
  parameter int IN_W = 43,
  parameter int RELU = 1
) (
  input  logic signed [IN_W-1:0] din,
  output logic signed [W-1:0]    dout
);

  logic signed [IN_W-1:0] shr;

  // arithmetic shift floors toward -inf
  assign shr = din >>> fraction_width;

  always_comb begin
    dout = shr[W-1:0];
    if (RELU != 0 && shr[IN_W-1]) begin
      dout = '0;
    end else if (shr > IN_W'(SAT_MAX)) begin
      dout = SAT_MAX;
    end else if (shr < IN_W'(SAT_MIN)) begin
      dout = SAT_MIN;
    end
  end

endmodule

// File: rtl/dense_layer.sv
// dense_layer: fully-connected stage reading the pooled map,
// one MAC per cycle-group, biased, saturated results buffer.
module dense_layer
  import dense_layer_pkg::*;
#(
  parameter int IN_SIZE      = 4,
  parameter int OUT_SIZE     = 2,
  parameter int READ_LATENCY = 2,
  parameter int RELU         = 1
) (
  input  logic         clk,
  input  logic         reset,
  dense_layer_if.slave bus
);

  localparam int KW    = (IN_SIZE > 1) ? $clog2(IN_SIZE) : 1;
  localparam int OW    = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1;
  localparam int LW    = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam int ACC_W = 2*W + $clog2(IN_SIZE) + 1;
  localparam int NW    = OUT_SIZE * IN_SIZE;

  state_t                  state;
  logic                    in_done_q;
  logic                    start;
  logic [KW-1:0]           k;
  logic [OW-1:0]           o;
  logic [LW-1:0]           lat;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] sum;
  logic signed [2*W-1:0]   prod;
  logic signed [W-1:0]     sat;
  logic signed [W-1:0]     wt   [OUT_SIZE][IN_SIZE];
  logic signed [W-1:0]     bias [OUT_SIZE];
  logic signed [W-1:0]     res  [OUT_SIZE];

  assign start = bus.in_done && !in_done_q;
  assign prod  = $signed(bus.in_data) * wt[o][k];
  assign sum   = acc + ACC_W'(bias[o]) * ACC_W'(Q_ONE);

  fxp_saturate #(
    .IN_W (ACC_W),
    .RELU (RELU)
  ) u_sat (
    .din  (sum),
    .dout (sat)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= S_IDLE;
      in_done_q      <= 1'b0;
      bus.done       <= 1'b0;
      bus.in_enable  <= 1'b0;
      bus.in_address <= '0;
      k              <= '0;
      o              <= '0;
      lat            <= '0;
      acc            <= '0;
      for (int i = 0; i < OUT_SIZE; i++) begin
        bias[i] <= '0;
        res[i]  <= '0;
        for (int j = 0; j < IN_SIZE; j++) wt[i][j] <= '0;
      end
    end else begin
      in_done_q <= bus.in_done;
      unique case (state)
        S_IDLE: begin
          if (bus.weight_we) begin
            for (int i = 0; i < OUT_SIZE; i++) begin
              for (int j = 0; j < IN_SIZE; j++)
                if (bus.weight_addr == 10'(i*IN_SIZE + j))
                  wt[i][j] <= bus.weight_data;
              if (bus.weight_addr == 10'(NW + i))
                bias[i] <= bus.weight_data;
            end
          end
          if (start) begin
            bus.done <= 1'b0;
            acc      <= '0;
            o        <= '0;
            k        <= '0;
            state    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          bus.in_address <= 9'(k);
          bus.in_enable  <= 1'b1;
          lat            <= '0;
          state          <= S_WAIT;
        end
        S_WAIT: begin
          if (lat == LW'(READ_LATENCY - 1)) state <= S_MAC;
          else lat <= lat + 1'b1;
        end
        S_MAC: begin
          acc           <= acc + ACC_W'(prod);
          bus.in_enable <= 1'b0;
          if (k == KW'(IN_SIZE - 1)) begin
            state <= S_FINISH;
          end else begin
            k     <= k + 1'b1;
            state <= S_ISSUE;
          end
        end
        S_FINISH: begin
          res[o] <= sat;
          if (o == OW'(OUT_SIZE - 1)) begin
            state <= S_DONE;
          end else begin
            o     <= o + 1'b1;
            k     <= '0;
            acc   <= '0;
            state <= S_ISSUE;
          end
        end
        S_DONE: begin
          bus.done <= 1'b1;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.dense_output_data = '0;
    for (int i = 0; i < OUT_SIZE; i++)
      if (bus.dense_output_address == 9'(i))
        bus.dense_output_data = res[i];
  end

endmodule

// File: tb/tb_dense_layer.sv
// tb_dense_layer: RELU=1 and RELU=0 instances side by side,
// checked against an arithmetic dot-product reference.
module tb_dense_layer;
  import dense_layer_pkg::*;

  localparam int NI  = 4;
  localparam int NO  = 2;
  localparam int RL  = 2;
  localparam int LAT = NO * (NI * (RL + 2) + 1) + 1;
  localparam longint QMAX = (longint'(1) <<< (W - 1)) - 1;
  localparam longint QMIN = -(longint'(1) <<< (W - 1));

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dense_layer_if b ();
  dense_layer_if bn ();

  assign bn.in_done              = b.in_done;
  assign bn.weight_we            = b.weight_we;
  assign bn.weight_addr          = b.weight_addr;
  assign bn.weight_data          = b.weight_data;
  assign bn.dense_output_address = b.dense_output_address;

  dense_layer #(
    .IN_SIZE (NI), .OUT_SIZE (NO), .READ_LATENCY (RL), .RELU (1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (b)
  );

  dense_layer #(
    .IN_SIZE (NI), .OUT_SIZE (NO), .READ_LATENCY (RL), .RELU (0)
  ) dut_n (
    .clk   (clk),
    .reset (reset),
    .bus   (bn)
  );

  int pm [NI];
  int mw [NO][NI];
  int mb [NO];
  int n_cmp = 0;
  int n_bad = 0;

  // pooled map with a two-stage read pipeline
  logic [W-1:0] p1, p1n;
  always @(posedge clk) begin
    p1         <= W'(pm[b.in_address[1:0]]);
    b.in_data  <= p1;
    p1n        <= W'(pm[bn.in_address[1:0]]);
    bn.in_data <= p1n;
  end

  function automatic longint model(int o, bit relu);
    longint s = 0;
    for (int k = 0; k < NI; k++) s += longint'(pm[k]) * longint'(mw[o][k]);
    s += longint'(mb[o]) * Q_ONE;
    s = s >>> fraction_width;
    if (relu && s < 0) s = 0;
    if (s > QMAX) s = QMAX;
    if (s < QMIN) s = QMIN;
    return s;
  endfunction

  task automatic chk(string tag, longint got, longint exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic rd(int a, output longint v, output longint vn);
    @(negedge clk);
    b.dense_output_address = 9'(a);
    #1;
    v  = $signed(b.dense_output_data);
    vn = $signed(bn.dense_output_data);
  endtask

  task automatic wr(int a, int d);
    @(negedge clk);
    b.weight_we   = 1'b1;
    b.weight_addr = 10'(a);
    b.weight_data = W'(d);
    @(negedge clk);
    b.weight_we = 1'b0;
    if (a < NO * NI) mw[a / NI][a % NI] = d;
    else if (a < NO * (NI + 1)) mb[a - NO * NI] = d;
  endtask

  task automatic check_res(string tag);
    longint v, vn;
    for (int o = 0; o < NO; o++) begin
      rd(o, v, vn);
      chk($sformatf("%s_res%0d_relu", tag, o), v, model(o, 1));
      chk($sformatf("%s_res%0d_lin", tag, o), vn, model(o, 0));
    end
  endtask

  task automatic run(input int inj, input int abort, output int lat);
    @(negedge clk);
    b.in_done = 1'b0;
    @(negedge clk);
    b.in_done = 1'b1;
    @(posedge clk);
    #1;
    chk("done_clr", b.done, 0);
    lat = -1;
    for (int c = 1; c <= 200; c++) begin
      @(posedge clk);
      #1;
      b.weight_we = 1'b0;
      if (c == abort) begin
        reset = 1'b0;
        return;
      end
      if (c == inj) begin
        b.weight_we   = 1'b1;
        b.weight_addr = 10'd0;
        b.weight_data = W'(-3000);
      end
      if (c == 1) begin
        chk("rd_en", b.in_enable, 1);
        chk("rd_addr0", b.in_address, 0);
      end
      if (c == 5) chk("rd_addr1", b.in_address, 1);
      if (b.done) begin
        lat = c;
        break;
      end
    end
  endtask

  function automatic int rnd(int span);
    return int'($urandom_range(2 * span - 1)) - span;
  endfunction

  initial begin
    int     lat;
    longint v, vn;
    int     t1w [8];
    int     t1x [4];

    reset                  = 1'b0;
    b.in_done              = 1'b0;
    b.weight_we            = 1'b0;
    b.weight_addr          = '0;
    b.weight_data          = '0;
    b.dense_output_address = '0;
    repeat (3) @(negedge clk);
    chk("rst_done", b.done, 0);
    chk("rst_en", b.in_enable, 0);
    chk("rst_addr", b.in_address, 0);
    rd(0, v, vn);
    chk("rst_res0", v, 0);
    reset = 1'b1;

    t1w = '{1024, 1024, 1024, 1024, 512, -1024, 0, 2048};
    t1x = '{1024, 2048, -1024, 512};
    for (int i = 0; i < NI; i++) pm[i] = t1x[i];
    for (int i = 0; i < 8; i++) wr(i, t1w[i]);
    wr(8, 0);
    wr(9, 256);
    run(0, 0, lat);
    chk("latency", lat, LAT);
    chk("latency_abs", lat, 35);
    rd(0, v, vn);
    chk("t1_res0", v, 2560);
    rd(1, v, vn);
    chk("t1_res1_relu", v, 0);
    chk("t1_res1_lin", vn, -256);
    check_res("t1");
    rd(5, v, vn);
    chk("oob5", v, 0);
    rd(2, v, vn);
    chk("oob2", vn, 0);

    // in_done held high: new weight must not restart
    wr(2, -2048);
    repeat (6) @(posedge clk);
    #1;
    chk("hold_done", b.done, 1);
    chk("hold_en", b.in_enable, 0);
    run(0, 0, lat);
    chk("restart_lat", lat, LAT);
    check_res("restart");

    // write during computation is ignored
    run(7, 0, lat);
    chk("midwr_lat", lat, LAT);
    check_res("midwr");

    for (int i = 0; i < NI; i++) pm[i] = 523264;
    for (int i = 0; i < NI; i++) wr(i, 1024);
    wr(8, 0);
    run(0, 0, lat);
    rd(0, v, vn);
    chk("sat_max", vn, 524287);
    check_res("satp");
    for (int i = 0; i < NI; i++) wr(i, -1024);
    run(0, 0, lat);
    rd(0, v, vn);
    chk("sat_min", vn, -524288);
    chk("sat_min_relu", v, 0);
    check_res("satn");

    // abort inside neuron 0
    run(0, 10, lat);
    #1;
    chk("abort_done", b.done, 0);
    chk("abort_en", b.in_enable, 0);
    rd(0, v, vn);
    chk("abort_res0", vn, 0);
    rd(1, v, vn);
    chk("abort_res1", vn, 0);
    b.in_done = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < NO; i++) begin
      mb[i] = 0;
      for (int j = 0; j < NI; j++) mw[i][j] = 0;
    end
    for (int i = 0; i < NI; i++) pm[i] = t1x[i];
    run(0, 0, lat);
    chk("post_rst_lat", lat, LAT);
    check_res("zero_w");
    for (int i = 0; i < 8; i++) wr(i, t1w[i]);
    wr(8, 0);
    wr(9, 256);
    run(0, 0, lat);
    check_res("reload");

    for (int r = 0; r < 8; r++) begin
      int span;
      span = (r % 2 == 0) ? 4096 : 524288;
      for (int i = 0; i < NI; i++) pm[i] = rnd(span);
      for (int a = 0; a < NO * (NI + 1); a++) wr(a, rnd(span));
      wr(10 + r, rnd(span));
      run(0, 0, lat);
      chk($sformatf("rnd%0d_lat", r), lat, LAT);
      check_res($sformatf("rnd%0d", r));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
